// File: rtl/output_bram_drain_ctrl.sv
`default_nettype none
// ============================================================================
// output_bram_drain_ctrl : reads output BRAM rows and streams lanes one beat at a time
// Rev 1.0
// ============================================================================
module output_bram_drain_ctrl #(
  parameter int DW        = 16,
  parameter int NUM_BRAMS = 16,
  parameter int O_ADDR_W  = 10,
  parameter int RD_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_top,
  input  logic                          start,
  input  logic [O_ADDR_W-1:0]           base_addr,
  input  logic [O_ADDR_W:0]             num_rows,
  output logic                          ext_read_mode,
  output logic [NUM_BRAMS*O_ADDR_W-1:0] ext_read_addr_flat,
  input  logic [NUM_BRAMS*DW-1:0]       bram_read_data_flat,
  output logic [DW-1:0]                 m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          m_last,
  output logic                          busy,
  output logic                          done
);

  localparam int LW = (NUM_BRAMS > 1) ? $clog2(NUM_BRAMS) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [LW-1:0]     LANE_LAST = LW'(NUM_BRAMS - 1);
  localparam logic [2:0]        WAIT_LAST = 3'(RD_LAT);
  localparam logic [O_ADDR_W:0] ROW_ONE   = {{O_ADDR_W{1'b0}}, 1'b1};

  logic [2:0]          state_q, state_d;
  logic [O_ADDR_W-1:0] base_q, base_d;
  logic [O_ADDR_W:0]   num_rows_q, num_rows_d;
  logic [O_ADDR_W:0]   row_cnt_q, row_cnt_d;
  logic [LW-1:0]       lane_idx_q, lane_idx_d;
  logic [2:0]          wait_cnt_q, wait_cnt_d;
  logic [DW-1:0]       row_buf_q [NUM_BRAMS];
  logic [DW-1:0]       row_buf_d [NUM_BRAMS];

  logic [O_ADDR_W-1:0] rd_addr;
  logic [O_ADDR_W:0]   row_next;
  logic                lane_last;
  logic                last_row;

  // Address arithmetic is O_ADDR_W wide, so the row address wraps naturally.
  assign rd_addr   = base_q + row_cnt_q[O_ADDR_W-1:0];
  assign row_next  = row_cnt_q + ROW_ONE;
  assign lane_last = (lane_idx_q == LANE_LAST);
  assign last_row  = (row_next == num_rows_q);

  assign ext_read_mode = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_SEND);
  assign m_valid       = (state_q == S_SEND);
  assign m_data        = row_buf_q[lane_idx_q];
  assign m_last        = last_row && lane_last && m_valid;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);

  genvar g;
  generate
    for (g = 0; g < NUM_BRAMS; g++) begin : g_lane_addr
      assign ext_read_addr_flat[g*O_ADDR_W +: O_ADDR_W] = ext_read_mode ? rd_addr : '0;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    num_rows_d = num_rows_q;
    row_cnt_d  = row_cnt_q;
    lane_idx_d = lane_idx_q;
    wait_cnt_d = wait_cnt_q;
    row_buf_d  = row_buf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_rows != '0) begin
            base_d     = base_addr;
            num_rows_d = num_rows;
            row_cnt_d  = '0;
            state_d    = S_ISSUE;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_ISSUE: begin
        wait_cnt_d = 3'd1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          for (int i = 0; i < NUM_BRAMS; i++) begin
            row_buf_d[i] = bram_read_data_flat[i*DW +: DW];
          end
          lane_idx_d = '0;
          state_d    = S_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      S_SEND: begin
        if (m_ready) begin
          if (lane_last) begin
            row_cnt_d  = row_next;
            lane_idx_d = '0;
            state_d    = last_row ? S_FIN : S_ISSUE;
          end else begin
            lane_idx_d = lane_idx_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_top) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      num_rows_q <= '0;
      row_cnt_q  <= '0;
      lane_idx_q <= '0;
      wait_cnt_q <= '0;
      for (int i = 0; i < NUM_BRAMS; i++) begin
        row_buf_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_rows_q <= num_rows_d;
      row_cnt_q  <= row_cnt_d;
      lane_idx_q <= lane_idx_d;
      wait_cnt_q <= wait_cnt_d;
      row_buf_q  <= row_buf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_output_bram_drain_ctrl.sv
`default_nettype none
// Bench for output_bram_drain_ctrl: BRAM model, random backpressure, scoreboarded stream.
module tb_output_bram_drain_ctrl;
  localparam int DW     = 16;
  localparam int NB     = 16;
  localparam int AW     = 10;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_top = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [AW:0]       num_rows = '0;
  logic              ext_read_mode;
  logic [NB*AW-1:0]  ext_read_addr_flat;
  logic [NB*DW-1:0]  bram_read_data_flat;
  logic [DW-1:0]     m_data;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic              m_last;
  logic              busy;
  logic              done;

  output_bram_drain_ctrl #(.DW(DW), .NUM_BRAMS(NB), .O_ADDR_W(AW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_top(rst_top), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .ext_read_mode(ext_read_mode), .ext_read_addr_flat(ext_read_addr_flat),
    .bram_read_data_flat(bram_read_data_flat), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
    logic [AW-1:0] a;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] mem [DEPTH][NB];
  logic [NB*DW-1:0] pipe [RD_LAT];
  int  checks = 0;
  int  errors = 0;
  int  beats = 0;
  bit  rand_ready = 1'b0;
  bit  erm_seen = 1'b0;
  bit  prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [NB*DW-1:0] row_word(input logic [AW-1:0] a);
    logic [NB*DW-1:0] w;
    for (int l = 0; l < NB; l++) w[l*DW +: DW] = mem[a][l];
    return w;
  endfunction

  // BRAM: data for the presented address appears RD_LAT cycles later.
  always @(posedge clk) begin
    pipe[0] <= row_word(ext_read_addr_flat[AW-1:0]);
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bram_read_data_flat = pipe[RD_LAT-1];

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stability under backpressure, then scoreboard pop on each handshake.
  always @(negedge clk) begin
    beat_t e;
    if (ext_read_mode) erm_seen = 1'b1;
    if (rst_top) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_stable", m_valid && m_data == prev_data && m_last == prev_last,
              {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
      end
      if (m_valid && m_ready) begin
        beats++;
        if (sb.size() == 0) begin
          check("unexpected_beat", 1'b0, m_data, 0);
        end else begin
          e = sb.pop_front();
          check("beat_data", m_data == e.d, $signed(m_data), $signed(e.d));
          check("beat_last", m_last == e.last, m_last, e.last);
          check("beat_addr", ext_read_addr_flat == {NB{e.a}} && ext_read_mode,
                ext_read_addr_flat[AW-1:0], e.a);
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic push_expect(input int base, input int n);
    beat_t b;
    for (int r = 0; r < n; r++) begin
      for (int l = 0; l < NB; l++) begin
        b.a    = AW'((base + r) % DEPTH);
        b.d    = mem[b.a][l];
        b.last = (r == n - 1) && (l == NB - 1);
        sb.push_back(b);
      end
    end
  endtask

  task automatic pulse_start(input int base, input int n);
    @(posedge clk); #1;
    base_addr = AW'(base);
    num_rows  = (AW+1)'(n);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Runs a drain; checks latency when the stream is never back-pressured.
  task automatic run_drain(input int base, input int n, input bit chk_lat, input bit poke);
    int k;
    int b0;
    bit got;
    b0 = beats;
    got = 1'b0;
    erm_seen = 1'b0;
    push_expect(base, n);
    pulse_start(base, n);
    for (k = 1; k <= n * (NB + RD_LAT + 1) * 4 + 50; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_rise", busy == 1'b1, busy, 1);
      if (poke && k == 20) begin
        base_addr = AW'(base + 77);
        num_rows  = (AW+1)'(n + 3);
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, got, 1);
    if (got) begin
      if (n == 0) check("zero_rows_done_lat", k <= 2, k, 2);
      else if (chk_lat) check("done_latency", k == n * (NB + RD_LAT + 1) + 1, k, n * (NB + RD_LAT + 1) + 1);
      check("beat_count", beats - b0 == n * NB, beats - b0, n * NB);
      check("sb_empty", sb.size() == 0, sb.size(), 0);
      if (n == 0) check("zero_rows_no_read", erm_seen == 1'b0, erm_seen, 0);
      @(negedge clk);
      check("post_done", {done, busy, ext_read_mode, m_valid} == 4'b0, {done, busy, ext_read_mode, m_valid}, 0);
    end
    sb.delete();
  endtask

  initial begin
    int b0;
    bit reached;
    for (int a = 0; a < DEPTH; a++)
      for (int l = 0; l < NB; l++) mem[a][l] = DW'($urandom);
    for (int l = 0; l < NB; l++) mem[0][l] = DW'(l + 1);
    mem[5][3] = 16'h8000;
    mem[6][7] = 16'h7fff;
    mem[1021][0] = 16'h8000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {ext_read_addr_flat, m_data, m_valid, m_last, busy, done, ext_read_mode} == '0,
          {m_valid, busy, done, ext_read_mode}, 0);
    @(posedge clk); #1 rst_top = 1'b0;

    run_drain(0, 1, 1'b1, 1'b0);
    run_drain(1020, 8, 1'b1, 1'b0);
    run_drain(33, 0, 1'b0, 1'b0);
    rand_ready = 1'b1;
    run_drain(4, 4, 1'b0, 1'b0);
    rand_ready = 1'b0;
    run_drain(100, 3, 1'b1, 1'b1);

    // Reset mid-drain, then a fresh drain.
    b0 = beats;
    reached = 1'b0;
    push_expect(200, 3);
    pulse_start(200, 3);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (beats - b0 >= 20) begin
        reached = 1'b1;
        break;
      end
    end
    check("reached_beat20", reached, beats - b0, 20);
    @(posedge clk); #1 rst_top = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs", {ext_read_addr_flat, m_data, m_valid, m_last, busy, done, ext_read_mode} == '0,
          {m_valid, busy, done, ext_read_mode}, 0);
    @(posedge clk); #1 rst_top = 1'b0;
    sb.delete();
    run_drain(300, 2, 1'b1, 1'b0);

    run_drain(512, DEPTH, 1'b1, 1'b0);

    for (int t = 0; t < 6; t++) begin
      rand_ready = 1'($urandom_range(0, 1));
      run_drain(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 5)), !rand_ready, 1'b0);
    end
    rand_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
